// File: rtl/multiplier.sv
// Lane-parallel fixed-point multiplier for the convolver datapath.
// Each of the KERNEL_SIZE^2 lanes multiplies one signed pixel by its weight,
// rescales by FRAC_BITS (floor) and saturates to DATA_WIDTH. The vector is
// registered once, so results appear one clock after the inputs are sampled.
module multiplier #(
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_SIZE = 5,
    parameter int FRAC_BITS   = 8
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      in_valid,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] weights,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] pixel_data,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] result,
    output logic                                      out_valid,
    output logic [KERNEL_SIZE*KERNEL_SIZE-1:0]        overflow
);

    localparam int N  = KERNEL_SIZE * KERNEL_SIZE;
    localparam int PW = 2 * DATA_WIDTH;

    // Saturation bounds expressed at full product width so the comparison
    // against the scaled product is done in a single signed domain.
    localparam logic signed [PW-1:0] SAT_MAX = {{(DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    // Multiply, floor-scale and saturate one lane.
    // Returns {overflow_flag, saturated_value}.
    function automatic logic [DATA_WIDTH:0] mul_sat(
        input logic [DATA_WIDTH-1:0] w,
        input logic [DATA_WIDTH-1:0] x
    );
        logic signed [PW-1:0] w_ext;
        logic signed [PW-1:0] x_ext;
        logic signed [PW-1:0] prod;
        logic signed [PW-1:0] scaled;
        logic [DATA_WIDTH:0]  res;
        w_ext  = {{DATA_WIDTH{w[DATA_WIDTH-1]}}, w};
        x_ext  = {{DATA_WIDTH{x[DATA_WIDTH-1]}}, x};
        prod   = w_ext * x_ext;
        // Arithmetic shift truncates toward minus infinity, which is the
        // intended rounding for this datapath.
        scaled = prod >>> FRAC_BITS;
        if (scaled > SAT_MAX) begin
            res = {1'b1, SAT_MAX[DATA_WIDTH-1:0]};
        end else if (scaled < SAT_MIN) begin
            res = {1'b1, SAT_MIN[DATA_WIDTH-1:0]};
        end else begin
            res = {1'b0, scaled[DATA_WIDTH-1:0]};
        end
        return res;
    endfunction

    logic [N*DATA_WIDTH-1:0] lane_res_s;
    logic [N-1:0]            lane_ovf_s;

    logic [N*DATA_WIDTH-1:0] result_d,    result_q;
    logic [N-1:0]            overflow_d,  overflow_q;
    logic                    out_valid_d, out_valid_q;

    // One dedicated multiplier per lane; lanes share nothing.
    for (genvar k = 0; k < N; k++) begin : g_lane
        logic [DATA_WIDTH:0] sat_s;

        // Compute the saturated product for this lane.
        always_comb begin
            sat_s = mul_sat(weights[k*DATA_WIDTH +: DATA_WIDTH],
                            pixel_data[k*DATA_WIDTH +: DATA_WIDTH]);
        end

        assign lane_res_s[k*DATA_WIDTH +: DATA_WIDTH] = sat_s[DATA_WIDTH-1:0];
        assign lane_ovf_s[k]                          = sat_s[DATA_WIDTH];
    end

    // Load a new vector when inputs are valid, otherwise hold the last one.
    always_comb begin
        result_d    = result_q;
        overflow_d  = overflow_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            result_d   = lane_res_s;
            overflow_d = lane_ovf_s;
        end else begin
            result_d   = result_q;
            overflow_d = overflow_q;
        end
    end

    // Output registers; reset clears everything and drops any in-flight vector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q    <= {(N*DATA_WIDTH){1'b0}};
            overflow_q  <= {N{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign overflow  = overflow_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: directed and random vectors against a
// plain-arithmetic reference model of the per-lane fixed-point product.
module tb_multiplier;

    localparam int DW = 16;
    localparam int KS = 5;
    localparam int FB = 8;
    localparam int N  = KS * KS;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [N*DW-1:0]   weights;
    logic [N*DW-1:0]   pixel_data;
    logic [N*DW-1:0]   result;
    logic              out_valid;
    logic [N-1:0]      overflow;

    // Model state: what the outputs must show right now.
    logic [N*DW-1:0]   exp_res;
    logic [N-1:0]      exp_ovf;
    logic              exp_valid;

    int vectors;
    int miscompares;

    multiplier #(.DATA_WIDTH(DW), .KERNEL_SIZE(KS), .FRAC_BITS(FB)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .weights    (weights),
        .pixel_data (pixel_data),
        .result     (result),
        .out_valid  (out_valid),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact product, floor division by 2^FB, clamp to the signed range.
    function automatic logic [DW:0] ref_lane(input logic [DW-1:0] w, input logic [DW-1:0] x);
        longint p;
        longint s;
        longint div;
        div = longint'(1) << FB;
        p = longint'($signed(w)) * longint'($signed(x));
        if (p >= 0) s = p / div;
        else        s = -((-p + div - 1) / div);
        if (s > 32767)       return {1'b1, 16'h7FFF};
        else if (s < -32768) return {1'b1, 16'h8000};
        else                 return {1'b0, s[15:0]};
    endfunction

    task automatic model_load();
        logic [DW:0] r;
        for (int k = 0; k < N; k++) begin
            r = ref_lane(weights[k*DW +: DW], pixel_data[k*DW +: DW]);
            exp_res[k*DW +: DW] = r[DW-1:0];
            exp_ovf[k]          = r[DW];
        end
    endtask

    task automatic check_all(input string tag);
        vectors++;
        assert (result === exp_res) else begin
            miscompares++;
            $error("FAIL %s result: got %h expected %h", tag, result, exp_res);
        end
        assert (overflow === exp_ovf) else begin
            miscompares++;
            $error("FAIL %s overflow: got %h expected %h", tag, overflow, exp_ovf);
        end
        assert (out_valid === exp_valid) else begin
            miscompares++;
            $error("FAIL %s out_valid: got %b expected %b", tag, out_valid, exp_valid);
        end
    endtask

    // Check one lane against a hand-computed constant from the test plan.
    task automatic check_lane(input string tag, input int k, input logic [DW-1:0] val, input logic ovf);
        assert (result[k*DW +: DW] === val) else begin
            miscompares++;
            $error("FAIL %s lane %0d: got %h expected %h", tag, k, result[k*DW +: DW], val);
        end
        assert (overflow[k] === ovf) else begin
            miscompares++;
            $error("FAIL %s ovf lane %0d: got %b expected %b", tag, k, overflow[k], ovf);
        end
    endtask

    // Drive inputs on the falling edge, let one rising edge pass, then check.
    task automatic apply(input logic v, input string tag);
        @(negedge clk);
        in_valid = v;
        @(posedge clk);
        if (v) model_load();
        exp_valid = v;
        #1;
        check_all(tag);
    endtask

    task automatic randomize_inputs();
        for (int k = 0; k < N; k++) begin
            weights[k*DW +: DW]    = 16'($urandom);
            pixel_data[k*DW +: DW] = 16'($urandom);
        end
    endtask

    task automatic clear_model();
        exp_res   = '0;
        exp_ovf   = '0;
        exp_valid = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clear_model();

        // Reset held with valid random inputs.
        reset = 1'b1;
        in_valid = 1'b1;
        randomize_inputs();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // Nominal Q8.8: 2.0 * 3.0 = 6.0 in every lane.
        for (int k = 0; k < N; k++) begin
            weights[k*DW +: DW]    = 16'h0200;
            pixel_data[k*DW +: DW] = 16'h0300;
        end
        apply(1'b1, "nominal");
        check_lane("nominal", 12, 16'h0600, 1'b0);
        // Invalid cycle with different inputs: result held, valid drops.
        randomize_inputs();
        apply(1'b0, "nominal_hold");
        check_lane("nominal_hold", 0, 16'h0600, 1'b0);

        // Signed / fractional lanes on top of the nominal pattern.
        for (int k = 0; k < N; k++) begin
            weights[k*DW +: DW]    = 16'h0200;
            pixel_data[k*DW +: DW] = 16'h0300;
        end
        weights[0*DW +: DW] = 16'hFF00; pixel_data[0*DW +: DW] = 16'h0280;
        weights[1*DW +: DW] = 16'h0080; pixel_data[1*DW +: DW] = 16'h0080;
        weights[2*DW +: DW] = 16'h0001; pixel_data[2*DW +: DW] = 16'hFFFF;
        weights[3*DW +: DW] = 16'h0000; pixel_data[3*DW +: DW] = 16'h7FFF;
        apply(1'b1, "signed");
        check_lane("signed", 0, 16'hFD80, 1'b0);
        check_lane("signed", 1, 16'h0040, 1'b0);
        check_lane("signed", 2, 16'hFFFF, 1'b0);
        check_lane("signed", 3, 16'h0000, 1'b0);
        check_lane("signed", 4, 16'h0600, 1'b0);

        // Saturation in lanes 4..6.
        weights[4*DW +: DW] = 16'h7FFF; pixel_data[4*DW +: DW] = 16'h7FFF;
        weights[5*DW +: DW] = 16'h8000; pixel_data[5*DW +: DW] = 16'h7FFF;
        weights[6*DW +: DW] = 16'h8000; pixel_data[6*DW +: DW] = 16'h8000;
        apply(1'b1, "saturate");
        check_lane("saturate", 4, 16'h7FFF, 1'b1);
        check_lane("saturate", 5, 16'h8000, 1'b1);
        check_lane("saturate", 6, 16'h7FFF, 1'b1);
        check_lane("saturate", 7, 16'h0600, 1'b0);
        assert (overflow === 25'h0000070) else begin
            miscompares++;
            $error("FAIL saturate ovf_vector: got %h expected %h", overflow, 25'h0000070);
        end

        // Streaming: back-to-back random vectors.
        for (int i = 0; i < 10; i++) begin
            randomize_inputs();
            apply(1'b1, "stream");
        end
        // Toggling valid: held values on invalid cycles.
        for (int i = 0; i < 8; i++) begin
            randomize_inputs();
            apply((i % 2) == 0, "toggle");
        end

        // Asynchronous reset between edges while a vector is in flight.
        randomize_inputs();
        apply(1'b1, "pre_async");
        randomize_inputs();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        clear_model();
        check_all("async_reset");
        @(posedge clk);
        #1;
        check_all("async_reset_hold");
        @(negedge clk);
        reset = 1'b0;

        // Lane independence: change one lane at a time against a fixed base.
        randomize_inputs();
        apply(1'b1, "indep_base");
        for (int k = 0; k < N; k++) begin
            logic [N*DW-1:0] prev;
            prev = exp_res;
            weights[k*DW +: DW]    = 16'($urandom);
            pixel_data[k*DW +: DW] = 16'($urandom);
            apply(1'b1, "indep");
            for (int j = 0; j < N; j++) begin
                if (j != k) begin
                    assert (result[j*DW +: DW] === prev[j*DW +: DW]) else begin
                        miscompares++;
                        $error("FAIL indep lane %0d moved when lane %0d driven: got %h expected %h",
                               j, k, result[j*DW +: DW], prev[j*DW +: DW]);
                    end
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multiplier.md
Name: multiplier

Overview:
- Lane-parallel fixed-point multiplier for the convolver datapath.
- Takes a flattened KERNEL_SIZE x KERNEL_SIZE window of signed pixels and the matching weights, and multiplies each pixel/weight pair element-wise.
- Produces KERNEL_SIZE^2 registered signed products in the same fixed-point format, feeding the downstream adder tree.
- No accumulation inside this block.

Parameters:
- DATA_WIDTH, 16, width of each signed fixed-point element (weight, pixel, result).
- KERNEL_SIZE, 5, kernel edge length; lane count N = KERNEL_SIZE^2.
- FRAC_BITS, 8, fractional bits of the format (default Q8.8).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  qualifies weights/pixel_data this cycle.
- weights  in  N*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH], signed two's complement.
- pixel_data  in  N*DATA_WIDTH  same lane packing as weights.
- result  out  N*DATA_WIDTH  lane k = product of lane k inputs, same packing.
- out_valid  out  1  result holds a new valid vector.
- overflow  out  N  per-lane flag: lane k saturated in the current result.

Behaviour:
- Reset (async assert, sync release on clk): result=0, out_valid=0, overflow=0.
- Latency is exactly 1 clock: inputs sampled on rising edge with in_valid=1 appear on result/out_valid after that edge.
- out_valid is a registered copy of in_valid; there is no backpressure.
- When in_valid=0:
  - result and overflow hold their previous values.
  - out_valid drops to 0 on the next edge.
- Per-lane arithmetic, identical and independent for all N lanes:
  - Full product p = signed(w) * signed(x), 2*DATA_WIDTH bits.
  - Scale by arithmetic right shift of FRAC_BITS: s = p >>> FRAC_BITS. Rounding is truncation toward minus infinity, no round-to-nearest.
  - If s fits in signed DATA_WIDTH: result lane = s[DATA_WIDTH-1:0], overflow bit = 0.
  - If s > max (0x7FFF for width 16): result lane = max, overflow bit = 1.
  - If s < min (0x8000): result lane = min, overflow bit = 1.
- overflow bits update only when in_valid=1, together with result.
- Lanes never interact; a saturating lane does not affect its neighbours.
- Reset asserted mid-stream clears outputs immediately; the in-flight vector is discarded.
- Fully synthesizable: generate loop over N lanes, one multiplier per lane. No lane sharing or time multiplexing.

Test Plan:
- Reset: assert reset with arbitrary inputs and in_valid=1 -> result=0, out_valid=0, overflow=0 while reset is high, including asynchronously between clock edges.
- Nominal Q8.8: all lanes weights=0x0200 (2.0), pixel_data=0x0300 (3.0), in_valid=1 for one cycle -> after 1 edge every lane=0x0600 (6.0), out_valid=1, overflow=0; next cycle out_valid=0, result held at 0x0600.
- Signed and fractional lanes, with truncation checked:
  - Lane 0: 0xFF00 (-1.0) x 0x0280 (2.5) -> 0xFD80 (-2.5).
  - Lane 1: 0x0080 (0.5) x 0x0080 (0.5) -> 0x0040 (0.25).
  - Lane 2: 0x0001 x 0xFFFF -> 0xFFFF (floor of -1/65536 LSB).
  - Lane 3: 0 x 0x7FFF -> 0x0000.
  - Other lanes unaffected.
- Saturation:
  - Lane 4: 0x7FFF x 0x7FFF -> 0x7FFF, overflow[4]=1.
  - Lane 5: 0x8000 x 0x7FFF -> 0x8000, overflow[5]=1.
  - Lane 6: 0x8000 x 0x8000 -> 0x7FFF, overflow[6]=1.
  - All other overflow bits 0.
- Streaming: 10 back-to-back vectors of random values with in_valid=1 continuously -> out_valid=1 every cycle, each result matching the reference model of its vector one cycle later. Then toggle in_valid 1/0 and confirm hold behaviour.
- Lane independence: drive a unique value pair in each of the 25 lanes, one lane at a time while the others stay constant -> only the driven lane's result changes.
